mgmt_bridge: RTL and testbench



---
 rtl/mgmt_bridge_if.sv | 28 ++
 rtl/mgmt_bridge.sv | 195 +++++++++++++++++++
 tb/tb_mgmt_bridge.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mgmt_bridge_if.sv
// mgmt_bridge_if: management register bus between mgmt_bridge and the register block.
//   rd_en    1   one-cycle read strobe (bridge -> regs)
//   rd_addr  16  read address, held from rd_en until rd_valid
//   rd_valid 1   read data valid (regs -> bridge)
//   rd_data  8   read data
//   wr_en    1   one-cycle write strobe
//   wr_addr  16  write address
//   wr_data  8   write data
// Modports: master (bridge side), slave (register block side).
interface mgmt_bridge_if;
  logic        rd_en;
  logic [15:0] rd_addr;
  logic        rd_valid;
  logic [7:0]  rd_data;
  logic        wr_en;
  logic [15:0] wr_addr;
  logic [7:0]  wr_data;

  modport master (
    output rd_en, rd_addr, wr_en, wr_addr, wr_data,
    input  rd_valid, rd_data
  );

  modport slave (
    input  rd_en, rd_addr, wr_en, wr_addr, wr_data,
    output rd_valid, rd_data
  );
endinterface

// File: rtl/mgmt_bridge.sv
// mgmt_bridge: turns the QSPI PHY byte stream into single-byte accesses on the
// management register bus. A 16-bit header (addr[15]=1 read, 0 write) sets a
// 15-bit working address that auto-increments per data byte / read byte.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   start, stop    chip-select assert / deassert pulses from the PHY
//   rx_valid/data  received byte from the PHY
//   tx_req         PHY asks for the next read byte
//   tx_valid/data  read byte back to the PHY (tx_data held between pulses)
//   bus            register bus (mgmt_bridge_if.master)
//   busy           high whenever the FSM is not idle
//   timeout_err    sticky read-timeout flag (only with MGMT_BRIDGE_TIMEOUT_EN)
//
// Build option: define MGMT_BRIDGE_TIMEOUT_EN to add the read timeout
// (counter and timeout_err port; TIMEOUT_CYCLES is used only then).
module mgmt_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          stop,
  input  logic          rx_valid,
  input  logic [7:0]    rx_data,
  input  logic          tx_req,
  output logic          tx_valid,
  output logic [7:0]    tx_data,
  mgmt_bridge_if.master bus,
  output logic          busy
`ifdef MGMT_BRIDGE_TIMEOUT_EN
  ,
  output logic          timeout_err
`endif
);

  typedef enum logic [2:0] {
    StIdle,
    StAddrHi,
    StAddrLo,
    StWrite,
    StReadIdle,
    StReadWait,
    StDrain
  } state_e;

  state_e      state_q;
  logic [14:0] addr_q;
  logic [7:0]  addr_hi_q;      // header byte 0, bit 7 is the read flag
  logic        pending_start_q;
  logic        tmo_hit;

`ifdef MGMT_BRIDGE_TIMEOUT_EN
  localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  logic [CntW-1:0] tmo_cnt_q;

  assign tmo_hit = (tmo_cnt_q == CntW'(TIMEOUT_CYCLES - 1));

  // Counter spans READ_WAIT and DRAIN together, so a stop does not restart it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt_q   <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (state_q == StReadWait || state_q == StDrain) begin
        tmo_cnt_q <= tmo_cnt_q + 1'b1;
      end else begin
        tmo_cnt_q <= '0;
      end
      if (state_q == StReadWait && tmo_hit && !bus.rd_valid) begin
        timeout_err <= 1'b1;
      end else if (start) begin
        timeout_err <= 1'b0;
      end
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  assign busy = (state_q != StIdle);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= StIdle;
      addr_q          <= '0;
      addr_hi_q       <= '0;
      pending_start_q <= 1'b0;
      tx_valid        <= 1'b0;
      tx_data         <= '0;
      bus.rd_en       <= 1'b0;
      bus.rd_addr     <= '0;
      bus.wr_en       <= 1'b0;
      bus.wr_addr     <= '0;
      bus.wr_data     <= '0;
    end else begin
      tx_valid  <= 1'b0;
      bus.rd_en <= 1'b0;
      bus.wr_en <= 1'b0;

      unique case (state_q)
        StIdle: begin
          if (start) state_q <= StAddrHi;
        end

        StAddrHi: begin
          if (start) begin
            state_q <= StAddrHi;
          end else if (stop) begin
            state_q <= StIdle;
          end else if (rx_valid) begin
            addr_hi_q <= rx_data;
            state_q   <= StAddrLo;
          end
        end

        // The header completes here, so the next byte can already be data.
        StAddrLo: begin
          if (start) begin
            state_q <= StAddrHi;
          end else if (stop) begin
            state_q <= StIdle;
          end else if (rx_valid) begin
            addr_q  <= {addr_hi_q[6:0], rx_data};
            state_q <= addr_hi_q[7] ? StReadIdle : StWrite;
          end
        end

        // A byte arriving with start/stop is still written before leaving.
        StWrite: begin
          if (rx_valid) begin
            bus.wr_en   <= 1'b1;
            bus.wr_addr <= {1'b0, addr_q};
            bus.wr_data <= rx_data;
            addr_q      <= addr_q + 15'd1;
          end
          if (start) begin
            state_q <= StAddrHi;
          end else if (stop) begin
            state_q <= StIdle;
          end
        end

        // One rd_en per tx_req: reads can pop FIFOs, so nothing is prefetched.
        StReadIdle: begin
          if (start) begin
            state_q <= StAddrHi;
          end else if (stop) begin
            state_q <= StIdle;
          end else if (tx_req) begin
            bus.rd_en   <= 1'b1;
            bus.rd_addr <= {1'b0, addr_q};
            state_q     <= StReadWait;
          end
        end

        StReadWait: begin
          if (bus.rd_valid || tmo_hit) begin
            if (start || pending_start_q) begin
              state_q         <= StAddrHi;
              pending_start_q <= 1'b0;
            end else if (stop) begin
              state_q <= StIdle;
            end else begin
              tx_valid <= 1'b1;
              tx_data  <= bus.rd_valid ? bus.rd_data : 8'hFF;
              addr_q   <= addr_q + 15'd1;
              state_q  <= StReadIdle;
            end
          end else if (start) begin
            pending_start_q <= 1'b1;
          end else if (stop) begin
            state_q <= StDrain;
          end
        end

        // Outstanding read must complete before the bus is reused.
        StDrain: begin
          if (bus.rd_valid || tmo_hit) begin
            state_q         <= (start || pending_start_q) ? StAddrHi : StIdle;
            pending_start_q <= 1'b0;
          end else if (start) begin
            pending_start_q <= 1'b1;
          end else if (stop) begin
            state_q         <= StIdle;
            pending_start_q <= 1'b0;
          end
        end

        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mgmt_bridge.sv
// tb_mgmt_bridge: directed self-checking bench for mgmt_bridge. A small register
// model answers each rd_en after rsp_delay cycles with rd_data = rd_addr[7:0]
// (rsp_delay = 0 means never answer).
module tb_mgmt_bridge;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       tx_req = 1'b0;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       busy;
`ifdef MGMT_BRIDGE_TIMEOUT_EN
  logic       timeout_err;
`endif

  mgmt_bridge_if bus ();

  mgmt_bridge #(.TIMEOUT_CYCLES(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .stop     (stop),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .tx_req   (tx_req),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .bus      (bus.master),
    .busy     (busy)
`ifdef MGMT_BRIDGE_TIMEOUT_EN
    ,
    .timeout_err (timeout_err)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Register block model.
  int          rsp_delay = 1;
  int          rsp_cnt = 0;
  logic [15:0] rsp_addr = 16'h0;
  always @(negedge clk) begin
    bus.rd_valid = 1'b0;
    if (rsp_cnt != 0) begin
      rsp_cnt--;
      if (rsp_cnt == 0) begin
        bus.rd_valid = 1'b1;
        bus.rd_data  = rsp_addr[7:0];
      end
    end
    if (bus.rd_en === 1'b1) begin
      rsp_cnt  = rsp_delay;
      rsp_addr = bus.rd_addr;
    end
  end

  // Transaction logs, stamped with the cycle the strobe was high.
  int          wr_cyc[$];
  logic [15:0] wr_a[$];
  logic [7:0]  wr_d[$];
  logic [15:0] rd_a[$];
  int          tx_cyc[$];
  logic [7:0]  tx_d[$];
  always @(negedge clk) begin
    if (bus.wr_en === 1'b1) begin
      wr_cyc.push_back(cyc);
      wr_a.push_back(bus.wr_addr);
      wr_d.push_back(bus.wr_data);
    end
    if (bus.rd_en === 1'b1) rd_a.push_back(bus.rd_addr);
    if (tx_valid === 1'b1) begin
      tx_cyc.push_back(cyc);
      tx_d.push_back(tx_data);
    end
  end

  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    wr_cyc.delete(); wr_a.delete(); wr_d.delete();
    rd_a.delete(); tx_cyc.delete(); tx_d.delete();
  endtask

  task automatic send(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1; tick(); stop = 1'b0;
  endtask

  task automatic pulse_req();
    tx_req = 1'b1; tick(); tx_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    int n;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_tx_data", tx_data, 8'h00);
    check("rst_rd_en", bus.rd_en, 0);
    check("rst_rd_addr", bus.rd_addr, 16'h0000);
    check("rst_wr_en", bus.wr_en, 0);
    check("rst_wr_addr", bus.wr_addr, 16'h0000);
    check("rst_wr_data", bus.wr_data, 8'h00);
`ifdef MGMT_BRIDGE_TIMEOUT_EN
    check("rst_timeout_err", timeout_err, 0);
`endif
    rst_n = 1'b1;
    tick();

    // Write burst
    clear_logs();
    pulse_start();
    send(8'h00);
    send(8'h48);
    c = cyc;
    send(8'h34);
    send(8'h12);
    tick(); tick();
    check("wr_count", wr_a.size(), 2);
    check("wr0_addr", wr_a[0], 16'h0048);
    check("wr0_data", wr_d[0], 8'h34);
    check("wr0_lat", wr_cyc[0], c + 1);
    check("wr1_addr", wr_a[1], 16'h0049);
    check("wr1_data", wr_d[1], 8'h12);
    check("wr1_lat", wr_cyc[1], c + 2);
    check("wr_no_rd", rd_a.size(), 0);
    check("wr_busy", busy, 1);
    pulse_stop();
    check("wr_stop_idle", busy, 0);

    // Read burst
    clear_logs();
    rsp_delay = 1;
    pulse_start();
    send(8'h80);
    send(8'h00);
    for (int i = 0; i < 3; i++) begin
      c = cyc;
      pulse_req();
      repeat (3) tick();
      check("rd_lat", tx_cyc[i], c + 3);
    end
    check("rd_count", rd_a.size(), 3);
    check("rd_addr0", rd_a[0], 16'h0000);
    check("rd_addr1", rd_a[1], 16'h0001);
    check("rd_addr2", rd_a[2], 16'h0002);
    check("tx_count", tx_d.size(), 3);
    check("tx_data0", tx_d[0], 8'h00);
    check("tx_data1", tx_d[1], 8'h01);
    check("tx_data2", tx_d[2], 8'h02);
    check("tx_data_hold", tx_data, 8'h02);
    check("rd_addr_hold", bus.rd_addr, 16'h0002);
    pulse_stop();

    // Address wrap
    clear_logs();
    pulse_start();
    send(8'h7F);
    send(8'hFF);
    send(8'hAA);
    send(8'hBB);
    tick();
    check("wrap_count", wr_a.size(), 2);
    check("wrap_addr0", wr_a[0], 16'h7FFF);
    check("wrap_addr1", wr_a[1], 16'h0000);
    check("wrap_data1", wr_d[1], 8'hBB);
    pulse_stop();

    // Cut-short header, then data byte together with stop
    clear_logs();
    pulse_start();
    send(8'h00);
    pulse_stop();
    check("cut_idle", busy, 0);
    pulse_start();
    send(8'h00);
    send(8'h40);
    rx_valid = 1'b1; rx_data = 8'h77; stop = 1'b1;
    tick();
    rx_valid = 1'b0; stop = 1'b0;
    tick();
    check("stop_rx_count", wr_a.size(), 1);
    check("stop_rx_addr", wr_a[0], 16'h0040);
    check("stop_rx_data", wr_d[0], 8'h77);
    check("stop_rx_idle", busy, 0);

    // Abort: stop in READ_WAIT, response 5 cycles after rd_en
    clear_logs();
    rsp_delay = 5;
    pulse_start();
    send(8'h80);
    send(8'h10);
    c = cyc;
    pulse_req();
    pulse_stop();
    tick();
    check("abort_busy", busy, 1);
    n = 0;
    while (busy && n < 20) begin
      tick();
      n++;
    end
    check("abort_idle_cyc", cyc, c + 7);
    check("abort_no_tx", tx_d.size(), 0);
    check("abort_one_rd", rd_a.size(), 1);

    // Start during DRAIN
    clear_logs();
    rsp_delay = 4;
    pulse_start();
    send(8'h80);
    send(8'h20);
    pulse_req();
    pulse_stop();
    pulse_start();
    repeat (3) tick();
    check("drain_start_busy", busy, 1);
    send(8'h00);
    send(8'h05);
    send(8'h66);
    tick();
    check("drain_start_wr", wr_a.size(), 1);
    check("drain_start_addr", wr_a[0], 16'h0005);
    check("drain_start_data", wr_d[0], 8'h66);
    check("drain_start_no_tx", tx_d.size(), 0);
    pulse_stop();

`ifdef MGMT_BRIDGE_TIMEOUT_EN
    // Read timeout
    clear_logs();
    rsp_delay = 0;
    pulse_start();
    send(8'h80);
    send(8'h30);
    c = cyc;
    pulse_req();
    n = 0;
    while (tx_d.size() == 0 && n < 40) begin
      tick();
      n++;
    end
    tick();
    check("tmo_count", tx_d.size(), 1);
    check("tmo_data", tx_d[0], 8'hFF);
    check("tmo_cyc", tx_cyc[0], c + 17);
    check("tmo_err", timeout_err, 1);
    check("tmo_busy", busy, 1);
    pulse_stop();
    check("tmo_err_sticky", timeout_err, 1);
    pulse_start();
    check("tmo_err_clear", timeout_err, 0);
    pulse_stop();
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
